multi_cycle_core: RTL and testbench
===================================

MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: HALT_OPCODE, default 6'h3F, opcode that stops the core.
REQ-003 Parameter: NREGS, default 32, number of architectural registers (power of two, 2..32); register specifiers index modulo NREGS.
REQ-004 Port: clk  input  1  rising-edge clock; reset is asynchronous and active-low.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: mem_req  output  1  memory transaction request, shared by instruction fetch and data access.
REQ-007 Port: mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 Port: mem_addr  output  32  byte address, unaligned bits passed through unchecked.
REQ-009 Port: mem_wdata  output  32  store data; valid while mem_req=1 and mem_we=1.
REQ-010 Port: mem_ready  input  1  completes the current transaction in the cycle it is sampled high with mem_req=1.
REQ-011 Port: mem_rdata  input  32  read data, valid in the cycle mem_ready=1.
REQ-012 Port: pc  output  32  current program counter.
REQ-013 Port: halted  output  1  high once HALT_OPCODE has been decoded.
REQ-014 Port: dbg_addr  input  5  register-file debug read index.
REQ-015 Port: dbg_data  output  32  combinational register value at dbg_addr; reads 0 for index 0.

Function
REQ-016 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; one instruction in flight; no overlap.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold until mem_ready=1, then latch IR and go to DECODE.
REQ-018 MEM: mem_req=1, mem_addr=ALU result; lw reads, sw writes rs2 value; hold until mem_ready=1.
REQ-019 mem_req, mem_we, mem_addr and mem_wdata remain stable from assertion until the completing cycle; mem_ready with mem_req=0 is ignored.
REQ-020 Supported: R-type funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; bne 0x05; j 0x02; HALT_OPCODE.
REQ-021 Unsupported opcode or funct: executes as NOP (FETCH, DECODE, then FETCH), pc += 4, no state change.
REQ-022 Zero-wait cycle counts: R-type/addi 4 (F,D,E,WB); lw 5 (F,D,E,M,WB); sw 4 (F,D,E,M); beq/bne 3 (F,D,E); j 2 (F,D); each stalled mem cycle adds 1.
REQ-023 pc updates to pc+4 at end of FETCH; branch taken in EXEC sets pc = (pc_fetch+4) + (sext(imm16)<<2); j sets pc = {pc_fetch+4 [31:28], IR[25:0], 2'b00} at end of DECODE.
REQ-024 Immediates sign-extended to 32 bits; arithmetic wraps modulo 2^32, no overflow trap.
REQ-025 Destination rd for R-type, rt for addi/lw; write occurs at the WB clock edge only.
REQ-026 Register 0 reads 0; writes to it discarded.
REQ-027 HALT: entered from DECODE; pc stays at halt instruction address + 4; mem_req=0; halted=1; leaves only by reset.

Reset
REQ-028 rst_n low asynchronously forces: state FETCH, pc=RESET_PC, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, IR=0, all registers 0.
REQ-029 Reset asserted mid-transaction abandons it; no register write occurs; first fetch after rst_n rises starts on the next clock edge at RESET_PC.

Verification
REQ-030 Zero-wait memory, program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; halt -> $3=2, halted=1 after 14 cycles, pc=0x10.
REQ-031 sw $1,0x40($0) then lw $4,0x40($0) with mem_ready delayed 3 cycles per access -> write at addr 0x40 data 5, $4=5, mem signals stable throughout each stall.
REQ-032 beq $0,$0,+2 at pc 0x0 -> next fetch at 0xC; bne $0,$0,+2 -> next fetch at 0x4; j 0x100 -> next fetch at 0x400.
REQ-033 slt with $1=-1, $2=1 -> rd=1; sub 0x0 - 0x1 -> 0xFFFF_FFFF; addi $0,$0,7 -> dbg_data at index 0 stays 0.
REQ-034 Assert rst_n low during MEM stall of lw -> mem_req drops immediately, target register unchanged (0), post-reset fetch at RESET_PC.
REQ-035 Opcode 0x3E executed -> NOP, pc advances by 4, no mem write, core continues to next instruction.

Source files
------------

// File: rtl/multi_cycle_core.sv
// multi_cycle_core: non-pipelined MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) sharing one memory port.
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F,
  parameter int          NREGS       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        halted,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  localparam int IW = $clog2(NREGS);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, nxt;
  logic go, act, done, take;
  logic [31:0] ir, a, b, res, imm, alu;
  logic [31:0] rf [NREGS];
  logic [5:0] op, funct;
  logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_halt, is_valid;
  logic [IW-1:0] rs, rt, dst;
  assign op      = ir[31:26];
  assign funct   = ir[5:0];
  assign rs      = ir[21 +: IW];
  assign rt      = ir[16 +: IW];
  assign imm     = {{16{ir[15]}}, ir[15:0]};
  assign is_halt = op == HALT_OPCODE;
  assign is_r    = op == 6'h00 && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                   funct == 6'h25 || funct == 6'h2A);
  assign is_addi = op == 6'h08;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_bne  = op == 6'h05;
  assign is_j    = op == 6'h02;
  assign is_valid = is_r | is_addi | is_lw | is_sw | is_beq | is_bne | is_j;
  assign dst     = is_r ? ir[11 +: IW] : rt;
  assign alu     = !is_r ? a + imm : funct == 6'h22 ? a - b : funct == 6'h24 ? a & b :
                   funct == 6'h25 ? a | b : funct == 6'h2A ? {31'b0, $signed(a) < $signed(b)} : a + b;
  assign take    = is_beq ? a == b : is_bne & (a != b);
  // go holds the port idle for the first cycle after reset so the first fetch starts on the next edge
  assign act     = go && (state == FETCH || state == MEM);
  assign done    = act && mem_ready;
  assign dbg_data = rf[dbg_addr[IW-1:0]];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      FETCH:   nxt = done ? DECODE : FETCH;
      DECODE:  nxt = is_halt ? HALT : (is_valid && !is_j) ? EXEC : FETCH;
      EXEC:    nxt = (is_lw || is_sw) ? MEM : (is_beq || is_bne) ? FETCH : WB;
      MEM:     nxt = !done ? MEM : is_lw ? WB : FETCH;
      WB:      nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    mem_req   = act;
    mem_we    = act && state == MEM && is_sw;
    mem_addr  = !act ? '0 : state == FETCH ? pc : res;
    mem_wdata = mem_we ? b : '0;
    halted    = state == HALT;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      go  <= 1'b0;
      pc  <= RESET_PC;
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      res <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      go <= 1'b1;
      case (state)
        FETCH: if (done) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
          if (is_j && !is_halt) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        EXEC: begin
          res <= alu;
          if (take) pc <= pc + {imm[29:0], 2'b00};
        end
        MEM:     if (done && is_lw) res <= mem_rdata;
        WB:      if (dst != '0) rf[dst] <= res;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_multi_cycle_core.sv
// tb_multi_cycle_core: directed programs against a latency-configurable memory model.
module tb_multi_cycle_core;
  logic        clk = 0, rst_n = 0;
  logic        mem_req, mem_we, mem_ready = 0, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, pc, dbg_data;
  logic [4:0]  dbg_addr = 0;
  logic [31:0] img [1024];
  logic [31:0] log_q [$];
  logic [31:0] wr_addr = 0, wr_data = 0, snap_addr = 0, snap_wdata = 0;
  logic        have_wr = 0, pending = 0, snap_we = 0;
  int lat = 0, cnt = 0, nwrites = 0, viol = 0, n_cmp = 0, n_bad = 0;

  multi_cycle_core dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc),
    .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pending && rst_n && (mem_req !== 1'b1 || mem_we !== snap_we || mem_addr !== snap_addr ||
        mem_wdata !== snap_wdata)) viol++;
    if (mem_ready) cnt = 0;
    if (!rst_n || !mem_req) begin
      mem_ready = 0;
      cnt = 0;
    end else if (cnt >= lat) begin
      mem_ready = 1;
      mem_rdata = (have_wr && mem_addr == wr_addr) ? wr_data : img[mem_addr[11:2]];
    end else begin
      mem_ready = 0;
      cnt++;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      have_wr = 0;
      pending = 0;
      log_q.delete();
    end else begin
      pending = mem_req && !mem_ready;
      snap_we = mem_we;
      snap_addr = mem_addr;
      snap_wdata = mem_wdata;
      if (mem_req && mem_ready && mem_we) begin
        have_wr = 1;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
        nwrites++;
      end
      if (mem_req && mem_ready && !mem_we) log_q.push_back(mem_addr);
    end
  end

  function automatic logic [31:0] it(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] rt_op(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] f);
    return {6'h00, rs, rt, rd, 5'h00, f};
  endfunction
  localparam logic [31:0] HALT_I = {6'h3F, 26'h0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic begin_test(input int l);
    rst_n = 0;
    lat = l;
    for (int i = 0; i < 1024; i++) img[i] = 32'h0;
  endtask

  task automatic release_rst();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_to_halt(output int n);
    n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("halt_reached", {31'b0, halted}, 32'd1);
  endtask

  initial begin
    int n, w0;
    // straight-line arithmetic, zero-wait memory, cycle-exact
    begin_test(0);
    img[0] = it(6'h08, 0, 1, 16'd5);
    img[1] = it(6'h08, 0, 2, 16'hFFFD);
    img[2] = rt_op(1, 2, 3, 6'h20);
    img[3] = HALT_I;
    @(negedge clk);
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pc", pc, 0);
    check("rst_halted", {31'b0, halted}, 0);
    release_rst();
    @(negedge clk);
    #1;
    check("first_fetch_req", {31'b0, mem_req}, 1);
    check("first_fetch_addr", mem_addr, 0);
    n = 0;
    while (!halted && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t1_cycles", n, 14);
    check("t1_pc", pc, 32'h10);
    check_reg("t1_r1", 1, 32'd5);
    check_reg("t1_r2", 2, 32'hFFFF_FFFD);
    check_reg("t1_r3", 3, 32'd2);
    check("t1_idle_req", {31'b0, mem_req}, 0);

    // store then load with 3 stall cycles per access
    begin_test(3);
    img[0] = it(6'h08, 0, 1, 16'd5);
    img[1] = it(6'h2B, 0, 1, 16'h40);
    img[2] = it(6'h23, 0, 4, 16'h40);
    img[3] = HALT_I;
    w0 = nwrites;
    viol = 0;
    release_rst();
    run_to_halt(n);
    check("t2_nwrites", nwrites - w0, 1);
    check("t2_waddr", wr_addr, 32'h40);
    check("t2_wdata", wr_data, 32'd5);
    check_reg("t2_r4", 4, 32'd5);
    check("t2_stable", viol, 0);

    // beq taken
    begin_test(0);
    img[0] = it(6'h04, 0, 0, 16'd2);
    img[1] = it(6'h08, 0, 5, 16'd1);
    img[2] = it(6'h08, 0, 5, 16'd1);
    img[3] = HALT_I;
    release_rst();
    run_to_halt(n);
    check("beq_next_fetch", log_q.size() > 1 ? log_q[1] : 32'hDEAD, 32'hC);
    check("beq_pc", pc, 32'h10);
    check_reg("beq_r5", 5, 0);

    // bne not taken
    begin_test(0);
    img[0] = it(6'h05, 0, 0, 16'd2);
    img[1] = HALT_I;
    release_rst();
    run_to_halt(n);
    check("bne_next_fetch", log_q.size() > 1 ? log_q[1] : 32'hDEAD, 32'h4);
    check("bne_pc", pc, 32'h8);

    // jump
    begin_test(0);
    img[0] = {6'h02, 26'h100};
    img[256] = HALT_I;
    release_rst();
    run_to_halt(n);
    check("j_next_fetch", log_q.size() > 1 ? log_q[1] : 32'hDEAD, 32'h400);
    check("j_pc", pc, 32'h404);

    // logic / compare / r0 behaviour
    begin_test(0);
    img[0] = it(6'h08, 0, 1, 16'hFFFF);
    img[1] = it(6'h08, 0, 2, 16'd1);
    img[2] = rt_op(1, 2, 3, 6'h2A);
    img[3] = rt_op(0, 2, 4, 6'h22);
    img[4] = it(6'h08, 0, 0, 16'd7);
    img[5] = rt_op(1, 2, 5, 6'h24);
    img[6] = rt_op(0, 2, 6, 6'h25);
    img[7] = it(6'h08, 0, 7, 16'd9);
    img[8] = rt_op(2, 1, 7, 6'h2A);
    img[9] = HALT_I;
    release_rst();
    run_to_halt(n);
    check_reg("slt_neg_lt_pos", 3, 32'd1);
    check_reg("sub_wrap", 4, 32'hFFFF_FFFF);
    check_reg("r0_zero", 0, 32'd0);
    check_reg("and", 5, 32'd1);
    check_reg("or", 6, 32'd1);
    check_reg("slt_pos_lt_neg", 7, 32'd0);

    // unsupported opcode behaves as NOP
    begin_test(0);
    img[0] = it(6'h08, 0, 1, 16'd5);
    img[1] = {6'h3E, 26'h0};
    img[2] = it(6'h08, 1, 2, 16'd1);
    img[3] = HALT_I;
    w0 = nwrites;
    release_rst();
    run_to_halt(n);
    check("nop_fetch", log_q.size() > 2 ? log_q[2] : 32'hDEAD, 32'h8);
    check("nop_nwrites", nwrites - w0, 0);
    check_reg("nop_r2", 2, 32'd6);
    check("nop_pc", pc, 32'h10);

    // reset asserted during a stalled load
    begin_test(3);
    img[0] = it(6'h23, 0, 4, 16'h40);
    img[1] = HALT_I;
    img[16] = 32'h1234;
    release_rst();
    n = 0;
    while (!(mem_req && mem_addr == 32'h40) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("ld_stall_seen", {31'b0, mem_req && mem_addr == 32'h40}, 1);
    rst_n = 0;
    #1;
    check("abort_req", {31'b0, mem_req}, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_pc", pc, 0);
    check_reg("abort_r4", 4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    check("refetch_req", {31'b0, mem_req}, 1);
    check("refetch_addr", mem_addr, 0);
    run_to_halt(n);
    check_reg("rerun_r4", 4, 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
